// File: rtl/bg_planet_pkg.sv
// Planet table, palette and LFSR helper shared by the planet/starfield
// background generator and its per-planet distance units.
package bg_planet_pkg;

  localparam int unsigned MAX_PLANETS = 8;
  localparam logic [7:0]  LFSR_SEED   = 8'hA5;

  typedef logic [10:0] coord_t;
  typedef logic [5:0]  rgb_t;   // {R[1:0], G[1:0], B[1:0]}

  localparam coord_t PX_INIT [MAX_PLANETS] = '{
    11'd192, 11'd480, 11'd800, 11'd100, 11'd300, 11'd650, 11'd900, 11'd560
  };

  localparam coord_t PY [MAX_PLANETS] = '{
    11'd320, 11'd224, 11'd600, 11'd650, 11'd100, 11'd450, 11'd200, 11'd700
  };

  localparam logic [9:0] PR [MAX_PLANETS] = '{
    10'd48, 10'd64, 10'd40, 10'd30, 10'd24, 10'd36, 10'd20, 10'd28
  };

  localparam coord_t SPEED [MAX_PLANETS] = '{
    11'd1, 11'd2, 11'd3, 11'd1, 11'd2, 11'd1, 11'd4, 11'd2
  };

  localparam rgb_t RGB [MAX_PLANETS] = '{
    6'b11_01_00, 6'b00_01_11, 6'b10_11_01, 6'b01_01_11,
    6'b11_11_10, 6'b01_10_00, 6'b10_00_10, 6'b11_10_11
  };

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [23:0] radius_sq(input logic [9:0] r);
    return 24'(r) * 24'(r);
  endfunction

endpackage

// File: rtl/bg_planet_disc.sv
// One planet: scrolling x position, wrapped distance (S1) and squared
// distance (S2) from the current pixel to the planet centre.
module bg_planet_disc
  import bg_planet_pkg::*;
#(
  parameter int unsigned H_RES = 1024,
  parameter coord_t      PX0   = 11'd192,
  parameter coord_t      PY0   = 11'd320,
  parameter coord_t      SPD   = 11'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic [23:0] dist_sq
);

  localparam logic [10:0]        HRES_U = 11'(H_RES);
  localparam logic signed [11:0] HRES_S = 12'(H_RES);
  localparam logic signed [11:0] HALF_S = 12'(H_RES / 2);

  logic [10:0]        px;
  logic signed [11:0] dx_raw, dx_wrap, dy_raw;
  logic signed [11:0] dx_q, dy_q;
  logic signed [23:0] dx_sq, dy_sq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      px <= PX0;
    else if (step)
      px <= (px < SPD) ? px + HRES_U - SPD : px - SPD;
  end

  // Shortest horizontal distance on a screen that wraps every H_RES pixels
  always_comb begin
    dx_raw  = $signed({1'b0, pix_x}) - $signed({1'b0, px});
    dy_raw  = $signed({1'b0, pix_y}) - $signed({1'b0, PY0});
    dx_wrap = dx_raw;
    if (dx_raw > HALF_S)
      dx_wrap = dx_raw - HRES_S;
    else if (dx_raw < -HALF_S)
      dx_wrap = dx_raw + HRES_S;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_wrap;
      dy_q <= dy_raw;
    end
  end

  assign dx_sq = dx_q * dx_q;
  assign dy_sq = dy_q * dy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dist_sq <= '0;
    else
      dist_sq <= $unsigned(dx_sq) + $unsigned(dy_sq);
  end

endmodule

// File: rtl/bg_planet_field.sv
// Scrolling planet discs over a static twinkling starfield; 3-clock pixel
// pipeline producing registered 2-bit-per-channel colour.
module bg_planet_field
  import bg_planet_pkg::*;
#(
  parameter int unsigned H_RES       = 1024,
  parameter int unsigned V_RES       = 768,
  parameter int unsigned NUM_PLANETS = 4,
  parameter int unsigned COLOR_MODE  = 1,
  parameter logic [6:0]  STAR_KEY    = 7'h2A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bg_en,
  input  logic        pause,
  input  logic        video_active,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        vsync,
  output logic [1:0]  R,
  output logic [1:0]  G,
  output logic [1:0]  B
);

  if (NUM_PLANETS < 1 || NUM_PLANETS > MAX_PLANETS || H_RES > 2047 || V_RES > 2047) begin : g_cfg_check
    $error("bg_planet_field: unsupported configuration");
  end

  logic        vs_q1, vs_q2;
  logic        frame_tick, step;
  logic [7:0]  lfsr;
  logic [10:0] key;
  logic        va1, va2, en1, en2, star1, star2;
  logic [2:0]  twk1, twk2;
  logic [23:0] dist_sq [NUM_PLANETS];
  rgb_t        pix_c;
  logic        planet_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q1 <= 1'b0;
      vs_q2 <= 1'b0;
    end else begin
      vs_q1 <= vsync;
      vs_q2 <= vs_q1;
    end
  end

  assign frame_tick = vs_q1 & ~vs_q2;
  assign step       = frame_tick & bg_en & ~pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= LFSR_SEED;
    else if (step)
      lfsr <= lfsr_next(lfsr);
  end

  for (genvar i = 0; i < NUM_PLANETS; i++) begin : g_disc
    bg_planet_disc #(
      .H_RES (H_RES),
      .PX0   (PX_INIT[i]),
      .PY0   (PY[i]),
      .SPD   (SPEED[i])
    ) u_disc (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (step),
      .pix_x   (pix_x),
      .pix_y   (pix_y),
      .dist_sq (dist_sq[i])
    );
  end

  // Star decision is made up front; only the flag and twinkle phase travel
  assign key = pix_x ^ {pix_y[4:0], pix_y[10:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va1   <= 1'b0;
      en1   <= 1'b0;
      star1 <= 1'b0;
      twk1  <= '0;
      va2   <= 1'b0;
      en2   <= 1'b0;
      star2 <= 1'b0;
      twk2  <= '0;
    end else begin
      va1   <= video_active;
      en1   <= bg_en;
      star1 <= (key[6:0] == STAR_KEY);
      twk1  <= key[9:7];
      va2   <= va1;
      en2   <= en1;
      star2 <= star1;
      twk2  <= twk1;
    end
  end

  always_comb begin
    pix_c      = '0;
    planet_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_PLANETS; i++) begin
      if (!planet_hit && dist_sq[i] <= radius_sq(PR[i])) begin
        planet_hit = 1'b1;
        pix_c      = (COLOR_MODE == 0) ? {3{RGB[i][5:4]}} : RGB[i];
      end
    end
    if (!planet_hit && star2)
      pix_c = (twk2 == lfsr[2:0]) ? {3{2'd1}} : {3{2'd3}};
    if (!(va2 && en2))
      pix_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= pix_c[5:4];
      G <= pix_c[3:2];
      B <= pix_c[1:0];
    end
  end

endmodule

// File: tb/tb_bg_planet_field.sv
// Self-checking bench for bg_planet_field: RGB and mono instances driven in
// parallel, compared against an arithmetic model of planets and stars.
module tb_bg_planet_field;
  import bg_planet_pkg::*;

  localparam int NP = 4;
  localparam int HR = 1024;

  logic        clk = 1'b0;
  logic        rst_n, bg_en, pause, video_active, vsync;
  logic [10:0] pix_x, pix_y;
  logic [1:0]  r_c, g_c, b_c, r_m, g_m, b_m;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          px_m [NP];
  logic [7:0]  lfsr_m;

  always #5 clk = ~clk;

  bg_planet_field #(
    .H_RES(1024), .V_RES(768), .NUM_PLANETS(NP), .COLOR_MODE(1), .STAR_KEY(7'h2A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bg_en(bg_en), .pause(pause),
    .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y), .vsync(vsync),
    .R(r_c), .G(g_c), .B(b_c)
  );

  bg_planet_field #(
    .H_RES(1024), .V_RES(768), .NUM_PLANETS(NP), .COLOR_MODE(0), .STAR_KEY(7'h2A)
  ) dut_mono (
    .clk(clk), .rst_n(rst_n), .bg_en(bg_en), .pause(pause),
    .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y), .vsync(vsync),
    .R(r_m), .G(g_m), .B(b_m)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NP; i++) px_m[i] = int'(PX_INIT[i]);
    lfsr_m = 8'hA5;
  endtask

  task automatic model_tick();
    if (bg_en && !pause) begin
      for (int i = 0; i < NP; i++)
        px_m[i] = (px_m[i] < int'(SPEED[i])) ? px_m[i] + HR - int'(SPEED[i])
                                              : px_m[i] - int'(SPEED[i]);
      lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
    end
  endtask

  function automatic logic [5:0] model_pix(input int x, input int y, input bit mono);
    int dx, dy, k;
    logic [1:0] lvl;
    for (int i = 0; i < NP; i++) begin
      dx = x - px_m[i];
      if (dx > HR / 2) dx -= HR;
      else if (dx < -(HR / 2)) dx += HR;
      dy = y - int'(PY[i]);
      if (dx * dx + dy * dy <= int'(PR[i]) * int'(PR[i]))
        return mono ? {3{RGB[i][5:4]}} : RGB[i];
    end
    k = x ^ ((y % 32) * 64 + y / 32);
    if (k % 128 == 42) begin
      lvl = ((k / 128) % 8 == int'(lfsr_m % 8)) ? 2'd1 : 2'd3;
      return {3{lvl}};
    end
    return 6'd0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pulse_vsync();
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    model_tick();
  endtask

  task automatic probe(input int x, input int y, input logic va,
                       output logic [5:0] o, output logic [5:0] om);
    @(negedge clk);
    pix_x = 11'(x);
    pix_y = 11'(y);
    video_active = va;
    @(negedge clk);
    video_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
    o  = {r_c, g_c, b_c};
    om = {r_m, g_m, b_m};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; bg_en = 1'b0; pause = 1'b0; video_active = 1'b0;
    vsync = 1'b0; pix_x = '0; pix_y = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({r_c, g_c, b_c} !== 6'd0) begin
      n_fail++; $display("FAIL reset_rgb: got %b expected %b", {r_c, g_c, b_c}, 6'd0);
    end
    n_checks++;
    if ({r_m, g_m, b_m} !== 6'd0) begin
      n_fail++; $display("FAIL reset_mono: got %b expected %b", {r_m, g_m, b_m}, 6'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bg_en = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [5:0] o, om;
    probe(192, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b11_01_00) begin n_fail++; $display("FAIL basic_centre: got %b expected %b", o, 6'b11_01_00); end
    n_checks++;
    if (om !== 6'b11_11_11) begin n_fail++; $display("FAIL basic_centre_mono: got %b expected %b", om, 6'b11_11_11); end
    probe(240, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b11_01_00) begin n_fail++; $display("FAIL basic_edge_right: got %b expected %b", o, 6'b11_01_00); end
    probe(241, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'd0) begin n_fail++; $display("FAIL basic_outside: got %b expected %b", o, 6'd0); end
    probe(144, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b11_01_00) begin n_fail++; $display("FAIL basic_edge_left: got %b expected %b", o, 6'b11_01_00); end
    probe(192, 369, 1'b1, o, om);
    n_checks++;
    if (o !== model_pix(192, 369, 0)) begin n_fail++; $display("FAIL basic_below: got %b expected %b", o, model_pix(192, 369, 0)); end
  endtask

  task automatic test_scroll();
    logic [5:0] o, om;
    repeat (4) pulse_vsync();
    probe(188, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b11_01_00) begin n_fail++; $display("FAIL scroll_p0_centre: got %b expected %b", o, 6'b11_01_00); end
    probe(240, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'd0) begin n_fail++; $display("FAIL scroll_old_edge: got %b expected %b", o, 6'd0); end
    probe(472, 224, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b00_01_11) begin n_fail++; $display("FAIL scroll_p1_centre: got %b expected %b", o, 6'b00_01_11); end
    n_checks++;
    if (om !== 6'd0) begin n_fail++; $display("FAIL scroll_p1_mono: got %b expected %b", om, 6'd0); end
    probe(536, 224, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b00_01_11) begin n_fail++; $display("FAIL scroll_p1_edge: got %b expected %b", o, 6'b00_01_11); end
  endtask

  task automatic test_back_to_back(input int n, input string tag);
    logic [5:0] eq[$], emq[$];
    int xq[$], yq[$];
    int x, y, p, ys;
    logic va, en;
    logic [5:0] e, em;
    for (int k = 0; k < n + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        e = eq.pop_front(); em = emq.pop_front();
        x = xq.pop_front(); y = yq.pop_front();
        n_checks++;
        if ({r_c, g_c, b_c} !== e) begin
          n_fail++;
          $display("FAIL %s_rgb (%0d,%0d): got %b expected %b", tag, x, y, {r_c, g_c, b_c}, e);
        end
        n_checks++;
        if ({r_m, g_m, b_m} !== em) begin
          n_fail++;
          $display("FAIL %s_mono (%0d,%0d): got %b expected %b", tag, x, y, {r_m, g_m, b_m}, em);
        end
      end
      if (k < n) begin
        case ($urandom_range(0, 3))
          0: begin
            p = int'($urandom_range(0, NP - 1));
            x = (px_m[p] + int'($urandom_range(0, 140)) - 70 + HR) % HR;
            y = int'(PY[p]) + int'($urandom_range(0, 140)) - 70;
            if (y < 0) y = 0;
          end
          1: begin
            y  = int'($urandom_range(0, 767));
            ys = (y % 32) * 64 + y / 32;
            x  = int'($urandom_range(0, 7)) * 128 + (42 ^ (ys % 128));
          end
          default: begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 767));
          end
        endcase
        va = ($urandom_range(0, 7) != 0);
        en = ($urandom_range(0, 7) != 0);
        pix_x = 11'(x); pix_y = 11'(y); video_active = va; bg_en = en;
        eq.push_back((va && en) ? model_pix(x, y, 0) : 6'd0);
        emq.push_back((va && en) ? model_pix(x, y, 1) : 6'd0);
        xq.push_back(x); yq.push_back(y);
      end else begin
        video_active = 1'b0;
        bg_en = 1'b1;
      end
    end
  endtask

  task automatic test_pause();
    logic [5:0] o, om;
    pause = 1'b1;
    repeat (3) pulse_vsync();
    pause = 1'b0;
    bg_en = 1'b0;
    repeat (2) pulse_vsync();
    bg_en = 1'b1;
    probe(236, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b11_01_00) begin n_fail++; $display("FAIL pause_p0_edge: got %b expected %b", o, 6'b11_01_00); end
    probe(237, 320, 1'b1, o, om);
    n_checks++;
    if (o !== model_pix(237, 320, 0)) begin n_fail++; $display("FAIL pause_p0_out: got %b expected %b", o, model_pix(237, 320, 0)); end
    probe(188, 320, 1'b0, o, om);
    n_checks++;
    if (o !== 6'd0) begin n_fail++; $display("FAIL inactive_hit: got %b expected %b", o, 6'd0); end
    bg_en = 1'b0;
    probe(188, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'd0) begin n_fail++; $display("FAIL disabled_hit: got %b expected %b", o, 6'd0); end
    bg_en = 1'b1;
    test_back_to_back(80, "paused_stream");
  endtask

  task automatic test_wrap();
    logic [5:0] o, om;
    int guard = 0;
    while (px_m[0] != 1023 && guard < 400) begin
      pulse_vsync();
      guard++;
    end
    probe(1023, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b11_01_00) begin n_fail++; $display("FAIL wrap_centre: got %b expected %b", o, 6'b11_01_00); end
    probe(47, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b11_01_00) begin n_fail++; $display("FAIL wrap_edge_right: got %b expected %b", o, 6'b11_01_00); end
    probe(48, 320, 1'b1, o, om);
    n_checks++;
    if (o !== model_pix(48, 320, 0)) begin n_fail++; $display("FAIL wrap_out_right: got %b expected %b", o, model_pix(48, 320, 0)); end
    probe(975, 320, 1'b1, o, om);
    n_checks++;
    if (o !== 6'b11_01_00) begin n_fail++; $display("FAIL wrap_edge_left: got %b expected %b", o, 6'b11_01_00); end
    probe(974, 320, 1'b1, o, om);
    n_checks++;
    if (o !== model_pix(974, 320, 0)) begin n_fail++; $display("FAIL wrap_out_left: got %b expected %b", o, model_pix(974, 320, 0)); end
  endtask

  task automatic test_ticks_stream();
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1, 6)) pulse_vsync();
      test_back_to_back(40, "tick_stream");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    pix_x = 11'd192; pix_y = 11'd320; video_active = 1'b1; bg_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({r_c, g_c, b_c} !== 6'd0) begin n_fail++; $display("FAIL midreset_clear: got %b expected %b", {r_c, g_c, b_c}, 6'd0); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({r_c, g_c, b_c} !== ((c < 3) ? 6'd0 : 6'b11_01_00)) begin
        n_fail++;
        $display("FAIL midreset_release_clk%0d: got %b expected %b", c, {r_c, g_c, b_c},
                 (c < 3) ? 6'd0 : 6'b11_01_00);
      end
      n_checks++;
      if ({r_m, g_m, b_m} !== ((c < 3) ? 6'd0 : 6'b11_11_11)) begin
        n_fail++;
        $display("FAIL midreset_mono_clk%0d: got %b expected %b", c, {r_m, g_m, b_m},
                 (c < 3) ? 6'd0 : 6'b11_11_11);
      end
    end
    video_active = 1'b0;
    test_back_to_back(80, "post_reset_stream");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scroll();
    test_pause();
    test_wrap();
    test_ticks_stream();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_planet_field.md
BG_PLANET_FIELD -- requirements
Module: bg_planet_field

Interface
REQ-001 The block SHALL have parameter H_RES, default 1024, meaning active pixels per line and horizontal wrap modulus.
REQ-002 The block SHALL have parameter V_RES, default 768, meaning active lines per frame.
REQ-003 The block SHALL have parameter NUM_PLANETS, default 4, range 1..8, meaning the number of planet entries taken from the package table.
REQ-004 The block SHALL have parameter COLOR_MODE, default 1: 0 = mono (G=B=R), 1 = full RGB palette.
REQ-005 The block SHALL have parameter STAR_KEY, default 7'h2A, meaning the hash match value that marks a star pixel.
REQ-006 The block SHALL have port clk, input, 1 bit: pixel clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port bg_en, input, 1 bit: block enable.
REQ-009 The block SHALL have port pause, input, 1 bit: freezes scroll and twinkle state.
REQ-010 The block SHALL have port video_active, input, 1 bit: current pixel is valid.
REQ-011 The block SHALL have ports pix_x and pix_y, input, 11 bits each: current pixel coordinates.
REQ-012 The block SHALL have port vsync, input, 1 bit: sampled in the clk domain, never used as a clock.
REQ-013 The block SHALL have ports R, G and B, output, 2 bits each: registered pixel colour.

Function
REQ-014 vsync SHALL be registered; frame_tick is 1 for exactly one clk on each detected 0->1 edge.
REQ-015 Each planet i SHALL hold an 11-bit px[i], initialised to PX_INIT[i]; on frame_tick with bg_en=1 and pause=0, px[i] = px[i]-SPEED[i], or px[i]+H_RES-SPEED[i] when px[i] < SPEED[i].
REQ-016 Horizontal distance SHALL be wrapped: dx = pix_x-px[i] (signed 12b), then dx-H_RES if dx > H_RES/2, or dx+H_RES if dx < -H_RES/2; dy = pix_y-PY[i].
REQ-017 The pixel path SHALL be three stages. S1 registers dx/dy. S2 registers dist_sq = dx*dx+dy*dy (unsigned 24b). S3 registers the colour. Total latency is exactly 3 clk from inputs to R/G/B.
REQ-018 video_active and bg_en SHALL be delayed 3 clk alongside the data; R=G=B=0 whenever the delayed video_active or delayed bg_en is 0.
REQ-019 Planet hit SHALL be defined as dist_sq <= PR[i]*PR[i] (boundary inclusive); the lowest-index hit planet wins.
REQ-020 Star hit SHALL be defined as key[6:0]==STAR_KEY, where key = pix_x ^ {pix_y[4:0],pix_y[10:5]}; stars are static and rank below all planets.
REQ-021 An 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5, SHALL step on every frame_tick under the same enable/pause gating as REQ-015.
REQ-022 Star brightness SHALL be 2'd1 when key[9:7]==lfsr[2:0], else 2'd3, applied to all three channels.
REQ-023 A pixel with no planet and no star hit SHALL output 0.
REQ-024 With COLOR_MODE=1, a planet SHALL output its RGB[i] from the package; with COLOR_MODE=0, G and B SHALL equal R.
REQ-025 When frame_tick coincides with a valid pixel, the updated px[i] SHALL apply from the next clk; pixels already in S1..S3 are unaffected.
REQ-026 bg_en=0 SHALL hold px[] and lfsr (no reload); pause=1 SHALL hold px[] and lfsr while the pixel path continues.

Reset
REQ-027 While rst_n=0: R/G/B=0, all pipeline registers=0, vsync register=0, px[i]=PX_INIT[i], lfsr=8'hA5.
REQ-028 Reset asserted mid-frame SHALL clear all pipeline stages immediately; the first non-zero output is no earlier than 3 clk after release.

Structure
REQ-029 Package bg_planet_pkg SHALL hold the tables PX_INIT, PY, PR, SPEED and RGB (8 entries each), plus LFSR_SEED. Default entry 0 = (192,320,48,1,3/1/0); entry 1 = (480,224,64,2,0/1/3).
REQ-030 Sub-module bg_planet_disc SHALL contain one planet's px register, wrap logic and S1/S2 stages; it is instantiated NUM_PLANETS times via generate.

Verification
REQ-031 After reset, pixel (192,320) active -> 3 clk later R=3, G=1, B=0; pixel (240,320) -> planet 0 colour; pixel (241,320), star-free -> 0.
REQ-032 Four vsync rising edges with pause=0 -> px[0]=188 and px[1]=472; pixel (188,320) coloured; pixel (240,320) -> 0.
REQ-033 Wrap: set PX_INIT[0]=0, SPEED 1, one frame_tick -> px[0]=1023; pixel (1023,320) and pixel (47,320) both hit.
REQ-034 pause=1 held over 3 vsync edges -> px[] and lfsr unchanged; video_active=0 at a hit pixel -> output 0 after 3 clk.
REQ-035 COLOR_MODE=0, pixel (192,320) -> R=G=B=3; rst_n pulsed mid-line -> outputs 0 for 3 clk after release and px[0]=192.
